// File: rtl/pcs_am_pkg.sv
// rtl/pcs_am_pkg.sv - shared constants, state encoding and idle-block test for the AM gap scheduler
package pcs_am_pkg;

   localparam logic [7:0] CGMII_IDLE  = 8'h07;
   localparam logic [7:0] CGMII_ERROR = 8'hFE;

   localparam int AM_PERIOD_DEF = 16384;
   localparam int N_AM_DEF      = 20;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_AM  = 1'b1
   } am_state_e;

   // An all-idle block is the only kind that may be deleted to win back AM slots.
   function automatic logic is_idle_block(input logic [63:0] data, input logic [7:0] ctrl);
      return (ctrl == 8'hFF) && (data == {8{CGMII_IDLE}});
   endfunction

endpackage

// File: rtl/am_gap_fifo.sv
// rtl/am_gap_fifo.sv - synchronous gap buffer holding blocks that arrive while AM slots are emitted
module am_gap_fifo #(
   parameter int WIDTH = 72,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;
   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign empty_o = (level_q == '0);

endmodule

// File: rtl/am_gap_scheduler.sv
// rtl/am_gap_scheduler.sv - inserts AM slots into the CGMII block stream, deleting idles to recover the gap
// Optional statistics counters are built when AM_GAP_STATS_EN is defined.
module am_gap_scheduler
   import pcs_am_pkg::*;
#(
   parameter int LEN_TX_DATA = 64,
   parameter int LEN_TX_CTRL = 8,
   parameter int AM_PERIOD   = AM_PERIOD_DEF,
   parameter int N_AM        = N_AM_DEF,
   parameter int FIFO_DEPTH  = 32
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_enable,
   input  logic                          i_am_bypass,
   input  logic [LEN_TX_DATA-1:0]        i_tx_data,
   input  logic [LEN_TX_CTRL-1:0]        i_tx_ctrl,
   output logic                          o_valid,
   output logic                          o_am_flag,
   output logic [LEN_TX_DATA-1:0]        o_tx_data,
   output logic [LEN_TX_CTRL-1:0]        o_tx_ctrl,
   output logic                          o_overflow,
`ifdef AM_GAP_STATS_EN
   output logic [31:0]                   o_idle_del_cnt,
   output logic [31:0]                   o_am_period_cnt,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int SW = $clog2(AM_PERIOD);
   localparam int CW = (N_AM > 1) ? $clog2(N_AM) : 1;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int FW = LEN_TX_DATA + LEN_TX_CTRL;

   localparam logic [SW-1:0]          SLOT_LAST = SW'(AM_PERIOD - N_AM - 1);
   localparam logic [CW-1:0]          AM_LAST   = CW'(N_AM - 1);
   localparam logic [LEN_TX_DATA-1:0] IDLE_DATA = {(LEN_TX_DATA/8){CGMII_IDLE}};
   localparam logic [LEN_TX_CTRL-1:0] IDLE_CTRL = '1;

   am_state_e               state_q, state_d;
   logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
   logic [CW-1:0]           am_cnt_q, am_cnt_d;
   logic                    valid_q, valid_d;
   logic                    am_flag_q, am_flag_d;
   logic                    overflow_q, overflow_d;
   logic [LEN_TX_DATA-1:0]  data_q, data_d;
   logic [LEN_TX_CTRL-1:0]  ctrl_q, ctrl_d;

   logic [LW-1:0]           level;
   logic [FW-1:0]           head;
   logic                    fifo_full, fifo_empty;
   logic                    in_idle, drop, push, pop;

   assign in_idle = is_idle_block(i_tx_data, i_tx_ctrl);

   am_gap_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (i_clock),
      .rst_n       (i_reset),
      .push_i      (push),
      .push_data_i ({i_tx_data, i_tx_ctrl}),
      .pop_i       (pop),
      .head_o      (head),
      .level_o     (level),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      slot_cnt_d = slot_cnt_q;
      am_cnt_d   = am_cnt_q;
      valid_d    = valid_q;
      am_flag_d  = am_flag_q;
      overflow_d = overflow_q;
      data_d     = data_q;
      ctrl_d     = ctrl_q;
      drop       = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;

      if (i_enable) begin
         drop = in_idle && (!fifo_empty || (state_q == ST_AM));
         if (state_q == ST_RUN) begin
            // With an empty buffer the input goes straight to the output register.
            pop       = !fifo_empty;
            push      = !drop && !fifo_empty;
            valid_d   = 1'b1;
            am_flag_d = 1'b0;
            {data_d, ctrl_d} = pop ? head : {i_tx_data, i_tx_ctrl};
            if (slot_cnt_q == SLOT_LAST) begin
               slot_cnt_d = '0;
               if (!i_am_bypass) begin
                  state_d  = ST_AM;
                  am_cnt_d = '0;
               end
            end else begin
               slot_cnt_d = slot_cnt_q + 1'b1;
            end
         end else begin
            push      = !drop;
            valid_d   = 1'b0;
            am_flag_d = 1'b1;
            data_d    = IDLE_DATA;
            ctrl_d    = IDLE_CTRL;
            if (am_cnt_q == AM_LAST) begin
               state_d    = ST_RUN;
               slot_cnt_d = '0;
            end else begin
               am_cnt_d = am_cnt_q + 1'b1;
            end
         end
         if (push && fifo_full && !pop) begin
            push       = 1'b0;
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= ST_RUN;
         slot_cnt_q <= '0;
         am_cnt_q   <= '0;
         valid_q    <= 1'b0;
         am_flag_q  <= 1'b0;
         overflow_q <= 1'b0;
         data_q     <= IDLE_DATA;
         ctrl_q     <= IDLE_CTRL;
      end else begin
         state_q    <= state_d;
         slot_cnt_q <= slot_cnt_d;
         am_cnt_q   <= am_cnt_d;
         valid_q    <= valid_d;
         am_flag_q  <= am_flag_d;
         overflow_q <= overflow_d;
         data_q     <= data_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign o_valid      = valid_q;
   assign o_am_flag    = am_flag_q;
   assign o_tx_data    = data_q;
   assign o_tx_ctrl    = ctrl_q;
   assign o_overflow   = overflow_q;
   assign o_fifo_level = level;

`ifdef AM_GAP_STATS_EN
   logic        am_start;
   logic [31:0] idle_del_cnt_q, am_period_cnt_q;

   assign am_start = i_enable && (state_q == ST_RUN) && (slot_cnt_q == SLOT_LAST) && !i_am_bypass;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         idle_del_cnt_q  <= '0;
         am_period_cnt_q <= '0;
      end else begin
         if (drop)     idle_del_cnt_q  <= idle_del_cnt_q + 32'd1;
         if (am_start) am_period_cnt_q <= am_period_cnt_q + 32'd1;
      end
   end

   assign o_idle_del_cnt  = idle_del_cnt_q;
   assign o_am_period_cnt = am_period_cnt_q;
`endif

endmodule

// File: tb/tb_am_gap_scheduler.sv
// tb/tb_am_gap_scheduler.sv - randomized self-checking bench for am_gap_scheduler against a queue model
module tb_am_gap_scheduler;

   localparam int AP = 64;
   localparam int NA = 4;
   localparam int FD = 8;
   localparam logic [71:0] IDLE_BLK = {{8{8'h07}}, 8'hFF};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        byp = 1'b0;
   logic [63:0] din = '0;
   logic [7:0]  cin = '0;
   logic        o_valid, o_am_flag, o_overflow;
   logic [63:0] o_tx_data;
   logic [7:0]  o_tx_ctrl;
   logic [3:0]  o_fifo_level;
`ifdef AM_GAP_STATS_EN
   logic [31:0] o_idle_del_cnt, o_am_period_cnt;
`endif

   always #5 clk = ~clk;

   am_gap_scheduler #(
      .LEN_TX_DATA (64),
      .LEN_TX_CTRL (8),
      .AM_PERIOD   (AP),
      .N_AM        (NA),
      .FIFO_DEPTH  (FD)
   ) dut (
      .i_clock         (clk),
      .i_reset         (rst_n),
      .i_enable        (en),
      .i_am_bypass     (byp),
      .i_tx_data       (din),
      .i_tx_ctrl       (cin),
      .o_valid         (o_valid),
      .o_am_flag       (o_am_flag),
      .o_tx_data       (o_tx_data),
      .o_tx_ctrl       (o_tx_ctrl),
      .o_overflow      (o_overflow),
`ifdef AM_GAP_STATS_EN
      .o_idle_del_cnt  (o_idle_del_cnt),
      .o_am_period_cnt (o_am_period_cnt),
`endif
      .o_fifo_level    (o_fifo_level)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: a block queue plus the position inside the 64-slot period (60 data, then 4 AM).
   logic [71:0] mq[$];
   int          pos;
   bit          m_valid, m_am, m_ovf;
   logic [71:0] m_out;
   int          m_drop, m_bursts;

   function automatic void model_reset();
      mq.delete();
      pos = 0; m_valid = 0; m_am = 0; m_ovf = 0; m_out = IDLE_BLK;
      m_drop = 0; m_bursts = 0;
   endfunction

   function automatic void model_step(input logic [71:0] blk, input bit bypass);
      bit idle = (blk == IDLE_BLK);
      if (pos < AP - NA) begin
         m_valid = 1; m_am = 0;
         if (mq.size() > 0) begin
            m_out = mq.pop_front();
            if (idle) m_drop++; else mq.push_back(blk);
         end else begin
            m_out = blk;
         end
      end else begin
         m_valid = 0; m_am = 1; m_out = IDLE_BLK;
         if (idle) m_drop++;
         else if (mq.size() == FD) m_ovf = 1;
         else mq.push_back(blk);
      end
      if (pos == AP - NA - 1) begin
         pos = bypass ? 0 : AP - NA;
         if (!bypass) m_bursts++;
      end else if (pos == AP - 1) begin
         pos = 0;
      end else begin
         pos++;
      end
   endfunction

   function automatic logic [95:0] exp_vec();
      return 96'({m_valid, m_am, m_ovf, 4'(mq.size()), m_out});
   endfunction

   function automatic logic [95:0] dut_vec();
      return 96'({o_valid, o_am_flag, o_overflow, o_fifo_level, o_tx_data, o_tx_ctrl});
   endfunction

   function automatic logic [71:0] rand_blk(input int idle_pct);
      logic [71:0] b;
      int r = int'($urandom_range(99));
      if (r < idle_pct) begin
         b = IDLE_BLK;
      end else if (r < idle_pct + 5) begin
         b = IDLE_BLK;
         b[8 + 8 * $urandom_range(7) +: 8] = 8'hFE;
      end else begin
         b = {$urandom, $urandom, 8'($urandom)};
      end
      return b;
   endfunction

   task automatic step(input logic e, input logic b, input logic [71:0] blk);
      @(negedge clk);
      en = e; byp = b; {din, cin} = blk;
      @(posedge clk);
      #1;
      if (e) model_step(blk, b);
      check("slot", dut_vec(), exp_vec());
`ifdef AM_GAP_STATS_EN
      check("idle_del_cnt", 96'(o_idle_del_cnt), 96'(m_drop));
      check("am_period_cnt", 96'(o_am_period_cnt), 96'(m_bursts));
`endif
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      en = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check(tag, dut_vec(), exp_vec());
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int cnt;
      int en_cnt;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_state", dut_vec(), exp_vec());
      rst_n = 1'b1;

      // Continuous non-idle data fills the buffer until a block is lost.
      cnt = 0;
      for (int i = 0; i < 3 * AP; i++) begin
         step(1'b1, 1'b0, {32'(i), 32'(i), 8'h00});
         if (i < AP && o_valid) cnt++;
      end
      check("s1_valid_per_period", 96'(cnt), 96'(AP - NA));
      check("s1_overflow", 96'(o_overflow), 96'(1));

      // Random traffic with plenty of idles: no loss, order kept.
      do_reset("s2_reset");
      for (int i = 0; i < 3 * AP; i++) step(1'b1, 1'b0, rand_blk(40));
      check("s2_no_overflow", 96'(o_overflow), 96'(0));
`ifdef AM_GAP_STATS_EN
      check("s2_bursts", 96'(o_am_period_cnt), 96'(3));
`endif

      // All idle; bypass raised after the first period allows exactly one burst.
      do_reset("s3_reset");
      cnt = 0;
      for (int i = 0; i < 4 * AP; i++) begin
         step(1'b1, (i >= AP) ? 1'b1 : 1'b0, IDLE_BLK);
         if (o_am_flag) cnt++;
      end
      check("s3_am_slots", 96'(cnt), 96'(NA));
      check("s3_valid_end", 96'(o_valid), 96'(1));

      // Enable toggling: disabled cycles carry garbage that must be ignored.
      do_reset("s4_reset");
      en_cnt = 0;
      for (int i = 0; en_cnt < 3 * AP; i++) begin
         if (i % 2 == 0) begin
            step(1'b1, 1'b0, rand_blk(40));
            en_cnt++;
         end else begin
            step(1'b0, 1'b0, {$urandom, $urandom, 8'($urandom)});
         end
      end

      // Reset in the middle of an AM burst with three blocks buffered.
      do_reset("s5_pre_reset");
      for (int i = 0; i < AP; i++) step(1'b1, 1'b0, {32'(i), 32'hA5A5_0000, 8'h01});
      for (int i = 0; i < AP - NA; i++)
         step(1'b1, 1'b0, (mq.size() > 1) ? IDLE_BLK : {32'(i), 32'h5A5A_0000, 8'h02});
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, {32'(i), 32'hC3C3_0000, 8'h03});
      check("s5_level_before", 96'(o_fifo_level), 96'(3));
      check("s5_am_before", 96'(o_am_flag), 96'(1));
      @(negedge clk);
      en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("s5_async_reset", dut_vec(), 96'({1'b0, 1'b0, 1'b0, 4'd0, IDLE_BLK}));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < AP; i++) begin
         step(1'b1, 1'b0, rand_blk(20));
         if (o_am_flag && cnt == 0) cnt = i;
      end
      check("s5_first_burst", 96'(cnt), 96'(AP - NA));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
